// File: rtl/evu_pkg.sv
// Shared types and constants for the event unit arbiter slice.
package evu_pkg;

   localparam int EVU_NUM_CH = 4;
   localparam int EVU_CNT_W  = 4;
   localparam int EVU_ASID_W = 16;
   localparam int EVU_PRIV_W = 2;
   localparam int EVU_INFO_W = EVU_PRIV_W + EVU_ASID_W;
   localparam int EVU_ID_W   = $clog2(EVU_NUM_CH);

   // Privilege level encoding carried in the top bits of the info word.
   typedef enum logic [EVU_PRIV_W-1:0] {
      PRIV_M = 2'b01,
      PRIV_S = 2'b10,
      PRIV_U = 2'b11
   } evu_priv_e;

   // Event packet at default sizing.
   typedef struct packed {
      logic [EVU_ID_W-1:0]   id;
      logic [EVU_INFO_W-1:0] info;
   } evu_pkt_t;

endpackage

// File: rtl/evu_rr_arbiter.sv
// Combinational round-robin pick: first requester after ptr, wrapping.
module evu_rr_arbiter
   import evu_pkg::*;
#(
   parameter int N = EVU_NUM_CH
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [$clog2(N)-1:0] gnt_idx,
   output logic                 gnt_vld
);

   localparam int IDW = $clog2(N);

   logic [IDW-1:0] idx;

   // Scan ptr+1 .. ptr+N (mod N); the first hit wins, so ptr itself is last.
   always_comb begin
      gnt_idx = '0;
      gnt_vld = 1'b0;
      idx     = '0;
      for (int i = 1; i <= N; i++) begin
         idx = IDW'((int'(ptr) + i) % N);
         if (!gnt_vld && req[idx]) begin
            gnt_idx = idx;
            gnt_vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/evu_event_arbiter.sv
// Event arbiter: per-channel saturating pending counters feeding a
// round-robin arbitrated single-entry output register (valid/ready).
module evu_event_arbiter
   import evu_pkg::*;
#(
   parameter int NUM_CH = EVU_NUM_CH,
   parameter int CNT_W  = EVU_CNT_W,
   parameter int INFO_W = EVU_INFO_W
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      en_i,
   input  logic                      flush_i,
   input  logic [NUM_CH-1:0]         event_i,
   input  logic [INFO_W-1:0]         info_i,
   output logic                      evt_valid_o,
   input  logic                      evt_ready_i,
   output logic [$clog2(NUM_CH)-1:0] evt_id_o,
   output logic [INFO_W-1:0]         evt_info_o,
   output logic [NUM_CH-1:0]         pending_o,
   output logic [NUM_CH-1:0]         ovf_o,
   input  logic                      ovf_clr_i
);

   localparam int ID_W = $clog2(NUM_CH);

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [INFO_W-1:0] info;
   } pkt_t;

   logic [NUM_CH-1:0][CNT_W-1:0]  cnt_q;
   logic [NUM_CH-1:0][INFO_W-1:0] info_q;
   logic [NUM_CH-1:0]             inc, dec, req, sat, ovf_set;
   logic [NUM_CH-1:0]             ovf_q;
   logic [ID_W-1:0]               ptr_q, gnt_idx;
   logic                          gnt_vld, load, valid_q;
   pkt_t                          pkt_q, pkt_d;

   // Grant is computed only from registered counters, never same-cycle incs.
   evu_rr_arbiter #(.N(NUM_CH)) u_rr (
      .req     (req),
      .ptr     (ptr_q),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld)
   );

   // The output slot is free when empty or being drained this cycle.
   assign load = (!valid_q || evt_ready_i) && gnt_vld && !flush_i;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign inc[c]     = event_i[c] & en_i;
      assign dec[c]     = load && (gnt_idx == ID_W'(c));
      assign req[c]     = |cnt_q[c];
      assign sat[c]     = &cnt_q[c];
      // Flush swallows the inc, so it cannot overflow either.
      assign ovf_set[c] = inc[c] & ~dec[c] & sat[c] & ~flush_i;

      // Pending counter: saturating up, down only when granted (never from 0).
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni)                         cnt_q[c] <= '0;
         else if (flush_i)                    cnt_q[c] <= '0;
         else if (inc[c] && !dec[c] && !sat[c]) cnt_q[c] <= cnt_q[c] + 1'b1;
         else if (dec[c] && !inc[c])          cnt_q[c] <= cnt_q[c] - 1'b1;
      end

      // Latest context info seen on this channel.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni)     info_q[c] <= '0;
         else if (inc[c]) info_q[c] <= info_i;
      end
   end

   // A same-cycle capture on the granted channel bypasses its latch.
   always_comb begin
      pkt_d.id   = gnt_idx;
      pkt_d.info = inc[gnt_idx] ? info_i : info_q[gnt_idx];
   end

   // Output register plus round-robin pointer; id/info held while stalled.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         pkt_q   <= '0;
         ptr_q   <= ID_W'(NUM_CH - 1);
      end else if (load) begin
         valid_q <= 1'b1;
         pkt_q   <= pkt_d;
         ptr_q   <= gnt_idx;
      end else if (valid_q && evt_ready_i) begin
         valid_q <= 1'b0;
      end
   end

   // Sticky overflow; a new overflow beats a same-cycle clear.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) ovf_q <= '0;
      else         ovf_q <= (ovf_clr_i ? '0 : ovf_q) | ovf_set;
   end

   assign evt_valid_o = valid_q;
   assign evt_id_o    = pkt_q.id;
   assign evt_info_o  = pkt_q.info;
   assign pending_o   = req;
   assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_evu_event_arbiter.sv
// Directed bench for evu_event_arbiter at default sizing (4 ch, 4-bit cnt).
module tb_evu_event_arbiter;
   import evu_pkg::*;

   logic        clk, rst_ni, en, flush, ready, ovf_clr;
   logic [3:0]  event_v;
   logic [17:0] info;
   logic        valid;
   logic [1:0]  id;
   logic [17:0] info_o;
   logic [3:0]  pending, ovf;

   int n_vec = 0;
   int n_err = 0;

   evu_event_arbiter dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .en_i        (en),
      .flush_i     (flush),
      .event_i     (event_v),
      .info_i      (info),
      .evt_valid_o (valid),
      .evt_ready_i (ready),
      .evt_id_o    (id),
      .evt_info_o  (info_o),
      .pending_o   (pending),
      .ovf_o       (ovf),
      .ovf_clr_i   (ovf_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one active edge; outputs are then sampled 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_ni = 1'b0; en = 1'b1; flush = 1'b0; ready = 1'b0; ovf_clr = 1'b0;
      event_v = '0; info = '0;
      step(); step();
      @(negedge clk);
      rst_ni = 1'b1;
      step();
   endtask

   task automatic test_reset();
      rst_ni = 1'b0; en = 1'b1; flush = 1'b0; ready = 1'b1; ovf_clr = 1'b0;
      event_v = '0; info = '0;
      step();
      n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid); end
      n_vec++; if (id !== 2'd0 || info_o !== 18'd0) begin n_err++; $display("FAIL reset_pkt: got id %0d info %h want 0/0", id, info_o); end
      n_vec++; if (pending !== 4'b0 || ovf !== 4'b0) begin n_err++; $display("FAIL reset_flags: got pend %b ovf %b want 0/0", pending, ovf); end
   endtask

   task automatic test_single();
      logic [17:0] x;
      x = {PRIV_S, 16'hA5C3};
      do_reset();
      ready = 1'b1; event_v = 4'b0100; info = x;
      step();
      event_v = '0; info = {PRIV_M, 16'h1111};
      n_vec++; if (valid !== 1'b0 || pending !== 4'b0100) begin n_err++; $display("FAIL single_t0: got valid %b pend %b want 0/0100", valid, pending); end
      step();
      n_vec++; if (valid !== 1'b1 || id !== 2'd2 || info_o !== x) begin n_err++; $display("FAIL single_pkt: got v%b id%0d info %h want v1 id2 info %h", valid, id, info_o, x); end
      n_vec++; if (pending !== 4'b0) begin n_err++; $display("FAIL single_pend: got %b want 0000", pending); end
      step();
      n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL single_drop: got %b want 0", valid); end
   endtask

   task automatic test_all_four();
      logic [17:0] x;
      x = {PRIV_U, 16'h0F0F};
      do_reset();
      ready = 1'b1; event_v = 4'b1111; info = x;
      step();
      event_v = '0;
      for (int k = 0; k < 4; k++) begin
         step();
         n_vec++; if (valid !== 1'b1 || id !== 2'(k) || info_o !== x) begin n_err++; $display("FAIL all4_pkt%0d: got v%b id%0d info %h want v1 id%0d info %h", k, valid, id, info_o, k, x); end
      end
      step();
      n_vec++; if (valid !== 1'b0 || ovf !== 4'b0) begin n_err++; $display("FAIL all4_end: got v%b ovf %b want 0/0000", valid, ovf); end
   endtask

   task automatic test_saturate();
      logic [17:0] held, last, second;
      int cnt;
      held = {PRIV_U, 16'd1};
      last = {PRIV_U, 16'd19};
      second = '0;
      do_reset();
      ready = 1'b0; event_v = 4'b0010;
      for (int i = 0; i < 20; i++) begin
         info = {PRIV_U, 16'(i)};
         step();
         if (i >= 2) begin
            n_vec++; if (valid !== 1'b1 || id !== 2'd1 || info_o !== held) begin n_err++; $display("FAIL sat_stall%0d: got v%b id%0d info %h want v1 id1 info %h", i, valid, id, info_o, held); end
         end
      end
      event_v = '0;
      n_vec++; if (ovf !== 4'b0010 || pending !== 4'b0010) begin n_err++; $display("FAIL sat_ovf: got ovf %b pend %b want 0010/0010", ovf, pending); end
      cnt = 1;
      ready = 1'b1;
      for (int k = 0; k < 40; k++) begin
         step();
         if (valid === 1'b1) begin
            cnt++;
            if (cnt == 2) second = info_o;
         end
      end
      n_vec++; if (cnt != 16) begin n_err++; $display("FAIL sat_count: got %0d packets want 16", cnt); end
      n_vec++; if (second !== last) begin n_err++; $display("FAIL sat_info: got %h want %h", second, last); end
      n_vec++; if (ovf !== 4'b0010) begin n_err++; $display("FAIL sat_sticky: got %b want 0010", ovf); end
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      n_vec++; if (ovf !== 4'b0000) begin n_err++; $display("FAIL sat_clr: got %b want 0000", ovf); end
   endtask

   task automatic test_fairness();
      do_reset();
      ready = 1'b1; event_v = 4'b1001; info = {PRIV_M, 16'h0042};
      step();
      for (int k = 0; k < 6; k++) begin
         step();
         n_vec++; if (valid !== 1'b1 || id !== ((k % 2 == 0) ? 2'd0 : 2'd3)) begin n_err++; $display("FAIL fair%0d: got v%b id%0d want v1 id%0d", k, valid, id, (k % 2 == 0) ? 0 : 3); end
      end
      event_v = '0;
   endtask

   task automatic test_flush();
      logic [17:0] x;
      x = {PRIV_S, 16'h7777};
      do_reset();
      ready = 1'b0; event_v = 4'b0111; info = x;
      step();
      event_v = '0;
      step();
      n_vec++; if (valid !== 1'b1 || id !== 2'd0 || pending !== 4'b0110) begin n_err++; $display("FAIL flush_pre: got v%b id%0d pend %b want v1 id0 0110", valid, id, pending); end
      flush = 1'b1; event_v = 4'b1000;
      step();
      flush = 1'b0; event_v = '0;
      n_vec++; if (pending !== 4'b0000 || valid !== 1'b1 || id !== 2'd0 || info_o !== x) begin n_err++; $display("FAIL flush_hold: got pend %b v%b id%0d info %h want 0000 v1 id0 %h", pending, valid, id, info_o, x); end
      ready = 1'b1;
      step();
      n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL flush_deliver: got v%b want 0", valid); end
      step();
      n_vec++; if (valid !== 1'b0 || pending !== 4'b0) begin n_err++; $display("FAIL flush_quiet: got v%b pend %b want 0/0000", valid, pending); end
   endtask

   task automatic test_enable();
      do_reset();
      ready = 1'b1; en = 1'b0; event_v = 4'b1111; info = {PRIV_M, 16'hBEEF};
      step(); step(); step();
      event_v = '0; en = 1'b1;
      n_vec++; if (pending !== 4'b0 || valid !== 1'b0) begin n_err++; $display("FAIL en_off: got pend %b v%b want 0000/0", pending, valid); end
   endtask

   task automatic test_async_reset();
      do_reset();
      ready = 1'b0; event_v = 4'b0010;
      for (int i = 0; i < 18; i++) step();
      event_v = '0;
      n_vec++; if (valid !== 1'b1 || ovf !== 4'b0010 || pending !== 4'b0010) begin n_err++; $display("FAIL arst_pre: got v%b ovf %b pend %b want v1 0010 0010", valid, ovf, pending); end
      #2 rst_ni = 1'b0;
      #1;
      n_vec++; if (valid !== 1'b0 || pending !== 4'b0 || ovf !== 4'b0) begin n_err++; $display("FAIL arst_now: got v%b pend %b ovf %b want 0/0000/0000", valid, pending, ovf); end
      @(negedge clk);
      rst_ni = 1'b1;
      step();
   endtask

   initial begin
      test_reset();
      test_single();
      test_all_four();
      test_saturate();
      test_fairness();
      test_flush();
      test_enable();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
